dram_device_model: RTL and testbench

// Synthesizable single-bank DRAM device that consumes the CSn/RASn/CASn/WEn/A/D command bus

---
 rtl/dram_device_model.sv | 183 ++++++++++++++++++
 tb/tb_dram_device_model.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_device_model.sv
// Single-bank DRAM device model: decodes the CSn/RASn/CASn/WEn command bus,
// keeps one open row, enforces ACT->column and PRE->ACT spacing, performs
// byte-masked writes and returns read data through a fixed-latency pipeline.
//
// Output contract: VALID is a one-cycle strobe with no back-pressure. Q carries
// the read word in the cycle VALID is high and holds its last value otherwise,
// so a consumer must capture Q in the cycle it sees VALID=1.
module dram_device_model #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int MEM_LOG2 = 16,
    parameter int CL       = 5,
    parameter int TRCD     = 3,
    parameter int TRP      = 3
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                CSn,
    input  logic                RASn,
    input  logic                CASn,
    input  logic [3:0]          WEn,
    input  logic [ROW_BITS-1:0] A,
    input  logic [31:0]         D,
    output logic [31:0]         Q,
    output logic                VALID,
    output logic                ERR,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_CLOSED = 2'd0,
        S_OPEN   = 2'd1,
        S_PRECHG = 2'd2
    } row_state_t;

    // Counters only need to reach the larger of the two spacings, then saturate.
    localparam int CNT_MAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TRCD_LAST = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP - 1);

    row_state_t            state_q, state_d;
    logic [ROW_BITS-1:0]   row_q;
    logic [CNT_W-1:0]      trcd_cnt, trp_cnt;
    logic                  act_go, pre_go, rd_go, wr_go, err_d;
    logic                  cmd_act, cmd_pre, cmd_rd, cmd_wr;
    logic [MEM_LOG2-1:0]   mem_idx;
    logic [31:0]           mem [2**MEM_LOG2];
    logic [CL-1:0]         vld_pipe;
    logic [31:0]           dat_pipe [CL];

    // Command decode; anything not matching one of the four commands is a NOP.
    assign cmd_act = !CSn && !RASn &&  CASn && (WEn == 4'hf);
    assign cmd_pre = !CSn && !RASn &&  CASn && (WEn != 4'hf);
    assign cmd_rd  = !CSn &&  RASn && !CASn && (WEn == 4'hf);
    assign cmd_wr  = !CSn &&  RASn && !CASn && (WEn != 4'hf);

    // Storage word index: low MEM_LOG2 bits of {row, column}; upper bits alias.
    assign mem_idx = MEM_LOG2'({row_q, A[COL_BITS-1:0]});

    assign dbg_state = state_q;
    assign VALID     = vld_pipe[CL-1];
    assign Q         = dat_pipe[CL-1];

    // Row state register, open-row address and error pulse.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_CLOSED;
            row_q   <= '0;
            ERR     <= 1'b0;
        end else begin
            state_q <= state_d;
            ERR     <= err_d;
            if (act_go) begin
                row_q <= A;
            end
        end
    end

    // Row FSM: accepts or rejects each command; a PRECHG whose tRP has elapsed
    // behaves exactly like CLOSED, so an ACT on that edge is accepted.
    always_comb begin
        state_d = state_q;
        act_go  = 1'b0;
        pre_go  = 1'b0;
        rd_go   = 1'b0;
        wr_go   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_CLOSED: begin
                if (cmd_act) begin
                    state_d = S_OPEN;
                    act_go  = 1'b1;
                end else if (cmd_pre || cmd_rd || cmd_wr) begin
                    err_d = 1'b1;
                end
            end
            S_OPEN: begin
                if (cmd_pre) begin
                    state_d = S_PRECHG;
                    pre_go  = 1'b1;
                end else if (cmd_act) begin
                    err_d = 1'b1;
                end else if (cmd_rd || cmd_wr) begin
                    if (trcd_cnt >= TRCD_LAST) begin
                        rd_go = cmd_rd;
                        wr_go = cmd_wr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRECHG: begin
                if (trp_cnt >= TRP_LAST) begin
                    if (cmd_act) begin
                        state_d = S_OPEN;
                        act_go  = 1'b1;
                    end else begin
                        state_d = S_CLOSED;
                        err_d   = cmd_pre || cmd_rd || cmd_wr;
                    end
                end else if (cmd_act || cmd_pre || cmd_rd || cmd_wr) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_CLOSED;
        endcase
    end

    // Saturating spacing counters, cleared on the accepted ACT / PRE edge.
    always_ff @(posedge CK) begin
        if (RST) begin
            trcd_cnt <= '0;
            trp_cnt  <= '0;
        end else begin
            if (act_go) begin
                trcd_cnt <= '0;
            end else if (trcd_cnt != CNT_SAT) begin
                trcd_cnt <= trcd_cnt + 1'b1;
            end
            if (pre_go) begin
                trp_cnt <= '0;
            end else if (trp_cnt != CNT_SAT) begin
                trp_cnt <= trp_cnt + 1'b1;
            end
        end
    end

    // Byte-masked write into the array; contents survive reset.
    always_ff @(posedge CK) begin
        if (wr_go && !RST) begin
            for (int i = 0; i < 4; i++) begin
                if (!WEn[i]) begin
                    mem[mem_idx][8*i +: 8] <= D[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: word captured on the READ edge, shifted CL-1 more times.
    // Data stages advance only behind a valid token so Q holds between reads.
    always_ff @(posedge CK) begin
        if (RST) begin
            vld_pipe <= '0;
            for (int i = 0; i < CL; i++) begin
                dat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_go;
            if (rd_go) begin
                dat_pipe[0] <= mem[mem_idx];
            end
            for (int i = 1; i < CL; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) begin
                    dat_pipe[i] <= dat_pipe[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_device_model.sv
// Bench for dram_device_model: directed protocol scenarios followed by a
// randomized command stream, all checked every cycle against a timestamp-based
// reference model of the device.
module tb_dram_device_model;

    localparam int ROW_BITS = 11;
    localparam int COL_BITS = 10;
    localparam int MEM_LOG2 = 16;
    localparam int CL       = 5;
    localparam int TRCD     = 3;
    localparam int TRP      = 3;

    // ---------------- clock / reset ----------------
    logic                CK = 1'b0;
    logic                RST = 1'b1;
    logic                CSn = 1'b1;
    logic                RASn = 1'b1;
    logic                CASn = 1'b1;
    logic [3:0]          WEn = 4'hf;
    logic [ROW_BITS-1:0] A = '0;
    logic [31:0]         D = '0;
    logic [31:0]         Q;
    logic                VALID;
    logic                ERR;
    logic [1:0]          dbg_state;

    always #5 CK = ~CK;

    dram_device_model #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .MEM_LOG2(MEM_LOG2),
        .CL(CL), .TRCD(TRCD), .TRP(TRP)
    ) dut (
        .CK(CK), .RST(RST), .CSn(CSn), .RASn(RASn), .CASn(CASn),
        .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID), .ERR(ERR),
        .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // Row status: 0 closed, 1 open, 2 precharging. Timing legality is derived
    // from edge timestamps of the last accepted ACT / PRE.
    int          n_checks = 0;
    int          n_pass   = 0;
    int          edge_n   = 0;
    int          m_st     = 0;
    int          m_row    = 0;
    int          act_edge = 0;
    int          pre_edge = 0;
    logic        m_err    = 1'b0;
    logic        m_valid  = 1'b0;
    logic [31:0] last_q_m = '0;
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] mem_m [int];

    function automatic int idx_of(input int row, input int col);
        return ((row << COL_BITS) | col) & ((1 << MEM_LOG2) - 1);
    endfunction

    task automatic model_edge();
        logic act, pre, rd, wr;
        int   key;
        logic [31:0] w;
        edge_n++;
        m_err   = 1'b0;
        m_valid = 1'b0;
        if (RST) begin
            m_st = 0;
            exp_q.delete();
            due_q.delete();
            last_q_m = '0;
            return;
        end
        act = !CSn && !RASn &&  CASn && (WEn == 4'hf);
        pre = !CSn && !RASn &&  CASn && (WEn != 4'hf);
        rd  = !CSn &&  RASn && !CASn && (WEn == 4'hf);
        wr  = !CSn &&  RASn && !CASn && (WEn != 4'hf);
        if (m_st == 2 && (edge_n - pre_edge) >= TRP) m_st = 0;
        key = idx_of(m_row, int'(A[COL_BITS-1:0]));
        if (act) begin
            if (m_st == 0) begin
                m_st = 1; m_row = int'(A); act_edge = edge_n;
            end else m_err = 1'b1;
        end else if (pre) begin
            if (m_st == 1) begin
                m_st = 2; pre_edge = edge_n;
            end else m_err = 1'b1;
        end else if (rd || wr) begin
            if (m_st == 1 && (edge_n - act_edge) >= TRCD) begin
                if (rd) begin
                    exp_q.push_back(mem_m.exists(key) ? mem_m[key] : 32'hx);
                    due_q.push_back(edge_n + CL - 1);
                end else begin
                    w = mem_m.exists(key) ? mem_m[key] : 32'hx;
                    for (int i = 0; i < 4; i++)
                        if (!WEn[i]) w[8*i +: 8] = D[8*i +: 8];
                    mem_m[key] = w;
                end
            end else m_err = 1'b1;
        end
        if (due_q.size() > 0 && due_q[0] == edge_n) begin
            m_valid  = 1'b1;
            last_q_m = exp_q.pop_front();
            void'(due_q.pop_front());
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Drive one command, let the edge sample it, then compare outputs 1 ns later.
    task automatic cyc(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [ROW_BITS-1:0] a,
                       input logic [31:0] d);
        CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
        @(posedge CK);
        model_edge();
        #1;
        check("err", {31'd0, ERR}, {31'd0, m_err});
        check("valid", {31'd0, VALID}, {31'd0, m_valid});
        check("q", Q, last_q_m);
    endtask

    task automatic do_nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 4'hf, '0, '0);
    endtask
    task automatic do_act(input logic [ROW_BITS-1:0] row);
        cyc(1'b0, 1'b0, 1'b1, 4'hf, row, '0);
    endtask
    task automatic do_pre();
        cyc(1'b0, 1'b0, 1'b1, 4'h0, '0, '0);
    endtask
    task automatic do_rd(input logic [ROW_BITS-1:0] col);
        cyc(1'b0, 1'b1, 1'b0, 4'hf, col, '0);
    endtask
    task automatic do_wr(input logic [ROW_BITS-1:0] col, input logic [31:0] d,
                         input logic [3:0] wen);
        cyc(1'b0, 1'b1, 1'b0, wen, col, d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        RST = 1'b1;
        do_nop(3);
        RST = 1'b0;

        // Full write then read back: VALID exactly CL cycles after READ
        do_act(11'h005);
        do_nop(TRCD - 1);
        do_wr(11'h010, 32'hDEADBEEF, 4'h0);
        do_rd(11'h010);
        do_nop(CL + 1);

        // Byte-masked write merges with the existing word
        do_wr(11'h020, 32'h11223344, 4'h0);
        do_wr(11'h020, 32'hAABBCCDD, 4'b1010);
        do_rd(11'h020);
        do_nop(CL + 1);

        // READ too early after ACT, then READ at exactly TRCD
        do_pre();
        do_nop(TRP - 1);
        do_act(11'h005);
        do_rd(11'h010);
        do_nop(TRCD - 2);
        do_rd(11'h010);
        do_nop(CL + 1);

        // Four back-to-back reads, PRE right after the last one
        for (int c = 0; c < 4; c++) do_wr(11'(c), $urandom, 4'h0);
        for (int c = 0; c < 4; c++) do_rd(11'(c));
        do_pre();

        // ACT at TRP-1 after PRE rejected, ACT at TRP accepted
        do_nop(TRP - 2);
        do_act(11'h005);
        do_act(11'h005);
        // ACT while OPEN rejected; row stays 0x005 for the following read
        do_act(11'h3ff);
        do_nop(TRCD - 2);
        do_rd(11'h000);
        do_nop(CL + 1);

        // PRE while CLOSED (after tRP expiry) rejected, twice
        do_pre();
        do_nop(TRP - 1);
        do_pre();
        do_pre();

        // Randomized command stream
        for (int k = 0; k < 400; k++) begin
            int sel;
            int col;
            int key;
            logic [ROW_BITS-1:0] a_r;
            sel = $urandom_range(0, 9);
            col = $urandom_range(0, 7);
            a_r = {1'($urandom_range(0, 1)), 7'd0, 3'(col)};
            key = idx_of(m_row, col);
            case (sel)
                0: do_act(11'($urandom_range(0, 3)));
                1: do_pre();
                2, 3, 4: begin
                    if (mem_m.exists(key)) do_rd(a_r);
                    else do_wr(a_r, $urandom, 4'h0);
                end
                5, 6: do_wr(a_r, $urandom, mem_m.exists(key) ? 4'($urandom_range(0, 14)) : 4'h0);
                7: cyc(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
                8: cyc(1'b0, 1'b0, 1'b0, 4'($urandom), 11'($urandom), $urandom);
                default: cyc(1'b0, 1'b1, 1'b1, 4'($urandom), 11'($urandom), $urandom);
            endcase
        end

        // Reset with two reads in flight; memory must survive
        do_nop(CL + TRP);
        do_pre();
        do_nop(TRP);
        do_act(11'h005);
        do_nop(TRCD - 1);
        do_rd(11'h010);
        do_rd(11'h020);
        RST = 1'b1;
        do_nop(2);
        RST = 1'b0;
        do_rd(11'h010);
        do_act(11'h005);
        do_nop(TRCD - 1);
        do_rd(11'h010);
        do_rd(11'h020);
        do_nop(CL + 1);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
